store_rmw_ctrl: RTL

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

---
 rtl/store_pkg.sv | 23 ++
 rtl/store_rmw_ctrl_breakmem.sv | 30 +++
 rtl/store_rmw_ctrl.sv | 111 +++++++++++
 3 files changed

// File: rtl/store_pkg.sv
// store_pkg: shared types for the store read-modify-write controller.
package store_pkg;

    // Store size as encoded on req_bmt.
    typedef enum logic [1:0] {
        BMT_SD = 2'b00,
        BMT_SW = 2'b01,
        BMT_SH = 2'b10,
        BMT_SB = 2'b11
    } bmt_t;

    // Controller sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WAIT  = 2'b10,
        WRITE = 2'b11
    } state_t;

    // Width of the read-latency counter; covers MEM_LAT up to 7.
    localparam int CNT_W = 3;

endpackage

// File: rtl/store_rmw_ctrl_breakmem.sv
// breakmem: merges the significant low bytes of a store into the doubleword
// read back from memory, according to the store size.
module breakmem
    import store_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  bmt_t              bmt,
    input  logic [DATA_W-1:0] st_data,
    input  logic [DATA_W-1:0] rd_data,
    output logic [DATA_W-1:0] wr_data
);

    logic [DATA_W-1:0] keep;

    // Select which low bits come from the store data; the rest come from memory.
    always_comb begin
        // NOTE: default assignment first so no path leaves keep unassigned (no latch).
        keep = '1;
        case (bmt)
            BMT_SD: keep = '1;
            BMT_SW: keep = DATA_W'(32'hFFFF_FFFF);
            BMT_SH: keep = DATA_W'(16'hFFFF);
            BMT_SB: keep = DATA_W'(8'hFF);
        endcase
    end

    assign wr_data = (st_data & keep) | (rd_data & ~keep);

endmodule

// File: rtl/store_rmw_ctrl.sv
// store_rmw_ctrl: performs doubleword, word, halfword and byte stores to a
// doubleword-wide memory. Full-width stores write directly; narrower stores
// read the doubleword, wait MEM_LAT cycles, merge, and write it back.
module store_rmw_ctrl
    import store_pkg::*;
#(
    parameter int DATA_W  = 64,
    parameter int ADDR_W  = 64,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_data,
    input  logic [1:0]        req_bmt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd_en,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              mem_wr_en,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              done,
    output logic              busy
);

    // Counter value on the last WAIT cycle, when read data is valid.
    localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MEM_LAT - 1);

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_data;
    bmt_t              lat_bmt;
    logic [DATA_W-1:0] rd_reg;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign mem_addr  = lat_addr;

    // Sequencer: accept a store, optionally read and wait, then write once.
    // Strobes are registered so each is high for exactly the state it belongs to.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the datapath registers are reset too, so mem_addr and
            // mem_wr_data read as zero while reset is held.
            state     <= IDLE;
            wait_cnt  <= '0;
            lat_addr  <= '0;
            lat_data  <= '0;
            lat_bmt   <= BMT_SD;
            rd_reg    <= '0;
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch sees
            // the pre-edge values of state and counters.
            mem_rd_en <= 1'b0;
            mem_wr_en <= 1'b0;
            done      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        lat_addr <= req_addr;
                        lat_data <= req_data;
                        lat_bmt  <= bmt_t'(req_bmt);
                        if (bmt_t'(req_bmt) == BMT_SD) begin
                            state     <= WRITE;
                            mem_wr_en <= 1'b1;
                            done      <= 1'b1;
                        end else begin
                            state     <= READ;
                            mem_rd_en <= 1'b1;
                        end
                    end
                end
                READ: begin
                    state    <= WAIT;
                    wait_cnt <= '0;
                end
                WAIT: begin
                    if (wait_cnt == WAIT_LAST) begin
                        rd_reg    <= mem_rd_data;
                        state     <= WRITE;
                        mem_wr_en <= 1'b1;
                        done      <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                WRITE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    breakmem #(
        .DATA_W (DATA_W)
    ) u_merge (
        .bmt     (lat_bmt),
        .st_data (lat_data),
        .rd_data (rd_reg),
        .wr_data (mem_wr_data)
    );

endmodule
